// File: rtl/imm_pkg.sv
// Shared format codes and RV32I major opcodes for immediate decode.
// Pure definitions; no logic.
// Used by the per-lane decoder and the decode stage.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_SHAMT   = 3'd6,
        FMT_ILLEGAL = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

endpackage

// File: rtl/imm_lane_dec.sv
// One RV32I instruction -> format code and sign-extended immediate.
// Latency: combinational.
// Backpressure: none; pure function of the instruction word.
module imm_lane_dec
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int FMT_W = 3
) (
    input  logic [31:0]      instr,
    output logic [FMT_W-1:0] fmt,
    output logic [XLEN-1:0]  imm
);

    fmt_e               f;
    logic signed [31:0] v;

    // Every immediate fits in 32 bits; the signed size cast widens it for XLEN=64.
    always_comb begin
        f = FMT_ILLEGAL;
        v = '0;
        if (instr[1:0] == 2'b11) begin
            case (instr[6:0])
                OP_IMM: begin
                    if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101) begin
                        f = FMT_SHAMT;
                        v = {27'b0, instr[24:20]};
                    end else begin
                        f = FMT_I;
                        v = {{20{instr[31]}}, instr[31:20]};
                    end
                end
                LOAD, JALR, SYSTEM: begin
                    f = FMT_I;
                    v = {{20{instr[31]}}, instr[31:20]};
                end
                STORE: begin
                    f = FMT_S;
                    v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                end
                BRANCH: begin
                    f = FMT_B;
                    v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                end
                LUI, AUIPC: begin
                    f = FMT_U;
                    v = {instr[31:12], 12'b0};
                end
                JAL: begin
                    f = FMT_J;
                    v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                end
                OP: begin
                    f = FMT_R;
                end
                default: begin
                    f = FMT_ILLEGAL;
                end
            endcase
        end
    end

    assign fmt = FMT_W'(f);
    assign imm = XLEN'(v);

endmodule

// File: rtl/imm_decode_stage.sv
// Multi-lane immediate decode stage with registered output and one-entry skid.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready = !skid_full (registered); holds up to 2 bundles.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int FMT_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       in_lane_valid,
    input  logic [LANES*32-1:0]    in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       out_lane_valid,
    output logic [LANES*32-1:0]    out_instr,
    output logic [LANES*XLEN-1:0]  out_imm,
    output logic [LANES*FMT_W-1:0] out_fmt
);

    localparam int BW = LANES * (1 + 32 + XLEN + FMT_W);

    logic [LANES*XLEN-1:0]  dec_imm;
    logic [LANES*FMT_W-1:0] dec_fmt;
    logic [BW-1:0]          new_bundle;
    logic [BW-1:0]          out_q;
    logic [BW-1:0]          skid_q;
    logic                   skid_full;
    logic                   accept;
    logic                   out_free;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [FMT_W-1:0] lane_fmt;
        logic [XLEN-1:0]  lane_imm;

        imm_lane_dec #(
            .XLEN  (XLEN),
            .FMT_W (FMT_W)
        ) u_dec (
            .instr (in_instr[32*k +: 32]),
            .fmt   (lane_fmt),
            .imm   (lane_imm)
        );

        // Empty lanes carry their word through but report no immediate.
        assign dec_imm[XLEN*k +: XLEN]   = in_lane_valid[k] ? lane_imm : '0;
        assign dec_fmt[FMT_W*k +: FMT_W] = in_lane_valid[k] ? lane_fmt : FMT_W'(FMT_R);
    end

    assign new_bundle = {in_lane_valid, in_instr, dec_imm, dec_fmt};
    assign in_ready   = !skid_full;
    assign accept     = in_valid && in_ready && !flush;
    assign out_free   = !out_valid || out_ready;

    // The skid only fills while the output is stalled, and always drains first.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
            out_q     <= '0;
            skid_q    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (out_free) begin
            if (skid_full) begin
                out_q     <= skid_q;
                out_valid <= 1'b1;
                skid_full <= 1'b0;
            end else if (accept) begin
                out_q     <= new_bundle;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q    <= new_bundle;
            skid_full <= 1'b1;
        end
    end

    assign {out_lane_valid, out_instr, out_imm, out_fmt} = out_q;

endmodule
